// File: rtl/time_counter_pkg.sv
// Shared clock/alarm constants, field types and the wrap-increment helper.
package time_counter_pkg;

  localparam int unsigned HOURS_PER_DAY = 24;
  localparam int unsigned MINS_PER_HOUR = 60;
  localparam int unsigned SECS_PER_MIN  = 60;

  localparam int unsigned HOUR_W = 5;
  localparam int unsigned MIN_W  = 6;
  localparam int unsigned SEC_W  = 6;
  localparam int unsigned BCD_W  = 8;

  typedef logic [HOUR_W-1:0] hour_t;
  typedef logic [MIN_W-1:0]  min_t;
  typedef logic [SEC_W-1:0]  sec_t;
  typedef logic [BCD_W-1:0]  bcd_t;

  localparam hour_t HOUR_LAST = hour_t'(HOURS_PER_DAY - 1);
  localparam min_t  MIN_LAST  = min_t'(MINS_PER_HOUR - 1);
  localparam sec_t  SEC_LAST  = sec_t'(SECS_PER_MIN - 1);

  // Compare-to-terminal increment; never produces a value past last.
  function automatic logic [5:0] inc_wrap(input logic [5:0] value, input logic [5:0] last);
    return (value == last) ? 6'd0 : value + 6'd1;
  endfunction

endpackage

// File: rtl/bin2bcd_2digit.sv
// Combinational 0..59 binary to two-digit BCD (tens in [7:4]).
module bin2bcd_2digit
  import time_counter_pkg::*;
(
  input  logic [5:0] bin,
  output bcd_t       bcd
);

  assign bcd = {4'(bin / 6'd10), 4'(bin % 6'd10)};

endmodule

// File: rtl/time_counter.sv
// 24-hour h:m:s counter with run prescaler, set strobes, day rollover pulse
// and registered binary plus BCD outputs.
module time_counter
  import time_counter_pkg::*;
#(
  parameter int unsigned CLK_PER_SEC = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hours,
  input  logic       mins,
  input  logic       secs,
  output logic [4:0] hour,
  output logic [5:0] minute,
  output logic [5:0] second,
  output logic [7:0] hour_bcd,
  output logic [7:0] minute_bcd,
  output logic [7:0] second_bcd,
  output logic       day_tick
);

  localparam int unsigned PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_SEC - 1);

  logic [PW-1:0] presc_q, presc_d;
  hour_t hour_q, hour_d;
  min_t  min_q, min_d;
  sec_t  sec_q, sec_d;
  bcd_t  hour_bcd_q, min_bcd_q, sec_bcd_q;
  bcd_t  hour_bcd_d, min_bcd_d, sec_bcd_d;
  logic  day_tick_q, day_tick_d;
  logic  set_mode;

  assign set_mode = hours | mins;

  always_comb begin
    presc_d    = presc_q;
    hour_d     = hour_q;
    min_d      = min_q;
    sec_d      = sec_q;
    day_tick_d = 1'b0;
    if (set_mode) begin
      // Set strobes never carry between fields and restart the second.
      presc_d = '0;
      sec_d   = '0;
      if (hours) hour_d = hour_t'(inc_wrap({1'b0, hour_q}, {1'b0, HOUR_LAST}));
      if (mins)  min_d  = inc_wrap(min_q, MIN_LAST);
    end else if (secs) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        sec_d   = inc_wrap(sec_q, SEC_LAST);
        if (sec_q == SEC_LAST) begin
          min_d = inc_wrap(min_q, MIN_LAST);
          if (min_q == MIN_LAST) begin
            hour_d     = hour_t'(inc_wrap({1'b0, hour_q}, {1'b0, HOUR_LAST}));
            day_tick_d = (hour_q == HOUR_LAST);
          end
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end else begin
      presc_d = '0;
    end
  end

  // BCD is derived from next-state so both output forms update on the same edge.
  bin2bcd_2digit u_hour_bcd (
    .bin ({1'b0, hour_d}),
    .bcd (hour_bcd_d)
  );

  bin2bcd_2digit u_min_bcd (
    .bin (min_d),
    .bcd (min_bcd_d)
  );

  bin2bcd_2digit u_sec_bcd (
    .bin (sec_d),
    .bcd (sec_bcd_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q    <= '0;
      hour_q     <= '0;
      min_q      <= '0;
      sec_q      <= '0;
      hour_bcd_q <= '0;
      min_bcd_q  <= '0;
      sec_bcd_q  <= '0;
      day_tick_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      hour_q     <= hour_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      hour_bcd_q <= hour_bcd_d;
      min_bcd_q  <= min_bcd_d;
      sec_bcd_q  <= sec_bcd_d;
      day_tick_q <= day_tick_d;
    end
  end

  assign hour       = hour_q;
  assign minute     = min_q;
  assign second     = sec_q;
  assign hour_bcd   = hour_bcd_q;
  assign minute_bcd = min_bcd_q;
  assign second_bcd = sec_bcd_q;
  assign day_tick   = day_tick_q;

endmodule
